jk_reg_arbiter: RTL and testbench

//  Shares one WIDTH-bit bank of JK storage cells between NREQ requesters.

---
 rtl/jk_reg_arbiter_pkg.sv | 36 +++
 rtl/jk_reg_arbiter_if.sv | 35 +++
 rtl/jk_reg_arbiter_rr.sv | 33 +++
 rtl/jk_reg_arbiter.sv | 159 +++++++++++++++
 tb/tb_jk_reg_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/jk_reg_arbiter_pkg.sv
// rtl/jk_reg_arbiter_pkg.sv - shared types, JK opcodes and next-state helper
// Purpose : FSM state type, per-bit JK opcode encodings and the vector
//           JK next-state function used by the bank register.
// Ports   : none (package jk_reg_pkg)
package jk_reg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Widest bank the helper supports; callers zero-pad and slice back.
  localparam int JK_MAXW = 64;

  function automatic logic [JK_MAXW-1:0] jk_next(input logic [JK_MAXW-1:0] j,
                                                 input logic [JK_MAXW-1:0] k,
                                                 input logic [JK_MAXW-1:0] q);
    logic [JK_MAXW-1:0] r;
    r = q;
    for (int b = 0; b < JK_MAXW; b++) begin
      case ({j[b], k[b]})
        JK_HOLD: r[b] = q[b];
        JK_CLR:  r[b] = 1'b0;
        JK_SET:  r[b] = 1'b1;
        default: r[b] = ~q[b];
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/jk_reg_arbiter_if.sv
// rtl/jk_reg_arbiter_if.sv - requester/bank bus bundle for jk_reg_arbiter
// Purpose : groups the per-requester command handshake and the bank outputs.
// Signals : req_valid/req_lock [NREQ], req_j/req_k [NREQ*WIDTH] (requester i
//           at [i*WIDTH +: WIDTH]), req_ready [NREQ], q/qbar [WIDTH], done,
//           done_id [clog2(NREQ)], owner_vld, lock_err.
// Modports: master = requester side, slave = arbiter/bank side.
interface jk_reg_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_lock;
  logic [NREQ*WIDTH-1:0] req_j;
  logic [NREQ*WIDTH-1:0] req_k;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qbar;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic                  owner_vld;
  logic                  lock_err;

  modport master (
    output req_valid, req_lock, req_j, req_k,
    input  req_ready, q, qbar, done, done_id, owner_vld, lock_err
  );

  modport slave (
    input  req_valid, req_lock, req_j, req_k,
    output req_ready, q, qbar, done, done_id, owner_vld, lock_err
  );

endinterface

// File: rtl/jk_reg_arbiter_rr.sv
// rtl/jk_reg_arbiter_rr.sv - combinational round-robin grant selector
// Purpose : picks the first asserted request at or after ptr (wrapping).
// Ports   : req [NREQ] in, ptr [clog2(NREQ)] in,
//           gnt [NREQ] out (one-hot or zero), gnt_id [clog2(NREQ)] out.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  int   idx;
  logic found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int o = 0; o < NREQ; o++) begin
      idx = (int'(ptr) + o) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/jk_reg_arbiter.sv
// rtl/jk_reg_arbiter.sv - round-robin arbitrated shared JK register bank
// Purpose : NREQ requesters issue per-bit J/K beats; one beat is granted per
//           cycle (round-robin, optional multi-beat lock with timeout) and
//           applied to the WIDTH-bit bank on the following edge.
// Ports   : clk, rst (async, active high), bus (jk_reg_arbiter_if.slave):
//           req_valid/req_lock/req_j/req_k in, req_ready/q/qbar/done/
//           done_id/owner_vld/lock_err out.
module jk_reg_arbiter
  import jk_reg_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int WIDTH        = 8,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  jk_reg_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(LOCK_TIMEOUT + 1);

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   owner;
  logic [TW-1:0]    tcnt;
  logic             owner_vld;
  logic             lock_err;

  logic             ap_vld;
  logic [WIDTH-1:0] ap_j;
  logic [WIDTH-1:0] ap_k;
  logic [IDW-1:0]   ap_id;

  logic [WIDTH-1:0] q;
  logic             done;
  logic [IDW-1:0]   done_id;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDW-1:0]   arb_id;
  logic [NREQ-1:0]  ready;
  logic [IDW-1:0]   acc_id;
  logic             acc;
  logic             acc_lock;
  logic [WIDTH-1:0] acc_j;
  logic [WIDTH-1:0] acc_k;
  logic [WIDTH-1:0] q_next;

  function automatic logic [IDW-1:0] id_inc(input logic [IDW-1:0] id);
    return (int'(id) == NREQ - 1) ? '0 : id + 1'b1;
  endfunction

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req    (bus.req_valid),
    .ptr    (ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  // While a lock is held the arbiter result is ignored and only the owner
  // can be accepted; during reset nothing is accepted.
  always_comb begin
    ready  = '0;
    acc_id = arb_id;
    if (!rst) begin
      if (state == IDLE) begin
        ready = arb_gnt;
      end else begin
        acc_id       = owner;
        ready[owner] = bus.req_valid[owner];
      end
    end
  end

  assign acc      = |ready;
  assign acc_lock = bus.req_lock[acc_id];
  assign acc_j    = bus.req_j[acc_id*WIDTH +: WIDTH];
  assign acc_k    = bus.req_k[acc_id*WIDTH +: WIDTH];

  logic [JK_MAXW-1:0] q_wide;
  assign q_wide = jk_next(JK_MAXW'(ap_j), JK_MAXW'(ap_k), JK_MAXW'(q));
  assign q_next = q_wide[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      tcnt      <= '0;
      owner_vld <= 1'b0;
      lock_err  <= 1'b0;
      ap_vld    <= 1'b0;
      ap_j      <= '0;
      ap_k      <= '0;
      ap_id     <= '0;
      q         <= '0;
      done      <= 1'b0;
      done_id   <= '0;
    end else begin
      lock_err <= 1'b0;

      // Apply stage: one registered beat per cycle, in acceptance order.
      ap_vld <= acc;
      if (acc) begin
        ap_j  <= acc_j;
        ap_k  <= acc_k;
        ap_id <= acc_id;
      end
      done <= ap_vld;
      if (ap_vld) begin
        q       <= q_next;
        done_id <= ap_id;
      end

      case (state)
        IDLE: begin
          if (acc) begin
            ptr <= id_inc(acc_id);
            if (acc_lock) begin
              state     <= OWNED;
              owner     <= acc_id;
              owner_vld <= 1'b1;
              tcnt      <= '0;
            end
          end
        end
        OWNED: begin
          // An owner beat takes priority over an expiring timeout.
          if (acc) begin
            if (acc_lock) begin
              tcnt <= '0;
            end else begin
              state     <= IDLE;
              owner_vld <= 1'b0;
              ptr       <= id_inc(owner);
            end
          end else if (tcnt == TW'(LOCK_TIMEOUT - 1)) begin
            state     <= IDLE;
            owner_vld <= 1'b0;
            lock_err  <= 1'b1;
            ptr       <= id_inc(owner);
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.q         = q;
  assign bus.qbar      = ~q;
  assign bus.done      = done;
  assign bus.done_id   = done_id;
  assign bus.owner_vld = owner_vld;
  assign bus.lock_err  = lock_err;

endmodule

// File: tb/tb_jk_reg_arbiter.sv
// tb/tb_jk_reg_arbiter.sv - scoreboard testbench for jk_reg_arbiter
module tb_jk_reg_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  jk_reg_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

  jk_reg_arbiter #(.NREQ(4), .WIDTH(8), .LOCK_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] id;
    logic [7:0] q;
  } exp_t;

  exp_t sb[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done actual id=%0d q=%h required no done", bus.done_id, bus.q);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_q", 32'(bus.q), 32'(e.q));
        chk("done_qbar", 32'(bus.qbar), 32'(8'(~e.q)));
        chk("done_id", 32'(bus.done_id), 32'(e.id));
      end
    end
  end

  function automatic void push(input logic [1:0] id, input logic [7:0] q);
    exp_t e;
    e.id = id;
    e.q  = q;
    sb.push_back(e);
  endfunction

  task automatic set_req(input int id, input logic v, input logic lk,
                         input logic [7:0] j, input logic [7:0] k);
    bus.req_valid[id]     = v;
    bus.req_lock[id]      = lk;
    bus.req_j[id*8 +: 8]  = j;
    bus.req_k[id*8 +: 8]  = k;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ready(input string nm, input logic [3:0] req);
    @(negedge clk);
    chk(nm, 32'(bus.req_ready), 32'(req));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.req_j     = '0;
    bus.req_k     = '0;
    repeat (3) step();
    // Reset state
    chk("rst_q", 32'(bus.q), 32'h00);
    chk("rst_qbar", 32'(bus.qbar), 32'hFF);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_done_id", 32'(bus.done_id), 32'h0);
    chk("rst_owner_vld", 32'(bus.owner_vld), 32'h0);
    chk("rst_lock_err", 32'(bus.lock_err), 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    rst = 1'b0;
    step();

    // Single beat: set low nibble
    set_req(0, 1'b1, 1'b0, 8'h0F, 8'h00);
    push(2'd0, 8'h0F);
    chk_ready("single_ready", 4'b0001);
    step();
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("single_q_pending", 32'(bus.q), 32'h00);
    step();

    // Toggle all then clear bits 5:4
    set_req(0, 1'b1, 1'b0, 8'hFF, 8'hFF);
    push(2'd0, 8'hF0);
    chk_ready("tgl_ready", 4'b0001);
    step();
    set_req(0, 1'b1, 1'b0, 8'h00, 8'h30);
    push(2'd0, 8'hC0);
    chk_ready("clr_ready", 4'b0001);
    step();
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) step();

    // Reset mid-beat: accepted lock beat from req1 is dropped
    set_req(1, 1'b1, 1'b1, 8'hAA, 8'h00);
    chk_ready("pre_rst_ready", 4'b0010);
    step();
    chk("pre_rst_owner_vld", 32'(bus.owner_vld), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_q", 32'(bus.q), 32'h00);
    chk("mid_rst_qbar", 32'(bus.qbar), 32'hFF);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    chk("mid_rst_owner_vld", 32'(bus.owner_vld), 32'h0);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    rst = 1'b0;
    repeat (4) step();
    chk("post_rst_q", 32'(bus.q), 32'h00);

    // Round-robin: all four valid, grants 0,1,2,3,0
    set_req(0, 1'b1, 1'b0, 8'h01, 8'h01);
    set_req(1, 1'b1, 1'b0, 8'h02, 8'h00);
    set_req(2, 1'b1, 1'b0, 8'h04, 8'h00);
    set_req(3, 1'b1, 1'b0, 8'h08, 8'h00);
    push(2'd0, 8'h01);
    push(2'd1, 8'h03);
    push(2'd2, 8'h07);
    push(2'd3, 8'h0F);
    push(2'd0, 8'h0E);
    chk_ready("rr_g0", 4'b0001); step();
    chk_ready("rr_g1", 4'b0010); step();
    chk_ready("rr_g2", 4'b0100); step();
    chk_ready("rr_g3", 4'b1000); step();
    chk_ready("rr_g4", 4'b0001); step();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) step();

    // Lock: req1 owns, req0/req2 stalled, then unlock -> req2, then req0
    set_req(1, 1'b1, 1'b1, 8'h10, 8'h00);
    push(2'd1, 8'h1E);
    chk_ready("lock_g1", 4'b0010);
    step();
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(0, 1'b1, 1'b0, 8'h00, 8'h01);
    set_req(2, 1'b1, 1'b0, 8'h40, 8'h00);
    for (int i = 0; i < 3; i++) begin
      chk_ready("lock_stall_ready", 4'b0000);
      chk("lock_owner_vld", 32'(bus.owner_vld), 32'h1);
      step();
    end
    set_req(1, 1'b1, 1'b0, 8'h80, 8'h00);
    push(2'd1, 8'h9E);
    chk_ready("unlock_g1", 4'b0010);
    step();
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    push(2'd2, 8'hDE);
    chk_ready("after_unlock_g2", 4'b0100);
    chk("after_unlock_owner_vld", 32'(bus.owner_vld), 32'h0);
    step();
    set_req(2, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(0, 1'b1, 1'b0, 8'h20, 8'h00);
    push(2'd0, 8'hFE);
    chk_ready("after_unlock_g0", 4'b0001);
    step();
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) step();

    // Timeout: req3 locks then goes idle; req0 waits
    set_req(3, 1'b1, 1'b1, 8'h00, 8'h80);
    push(2'd3, 8'h7E);
    chk_ready("to_g3", 4'b1000);
    step();
    set_req(3, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(0, 1'b1, 1'b0, 8'h00, 8'h7E);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("to_wait_lock_err", 32'(bus.lock_err), 32'h0);
      chk("to_wait_owner_vld", 32'(bus.owner_vld), 32'h1);
      chk("to_wait_ready", 32'(bus.req_ready), 32'h0);
      step();
    end
    push(2'd0, 8'h00);
    @(negedge clk);
    chk("to_lock_err", 32'(bus.lock_err), 32'h1);
    chk("to_owner_vld", 32'(bus.owner_vld), 32'h0);
    chk("to_ready", 32'(bus.req_ready), 32'h1);
    step();
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("to_lock_err_pulse", 32'(bus.lock_err), 32'h0);
    repeat (4) step();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
